// File: rtl/ring_pkg.sv
// Shared encodings for the ring-node transmit path: source codes, port tags
// and the per-port dispatch states.
package ring_pkg;

    localparam logic [1:0] SRC_LEFT    = 2'b00;
    localparam logic [1:0] SRC_SELF    = 2'b01;
    localparam logic [1:0] SRC_RIGHT   = 2'b10;
    localparam logic [1:0] SRC_INVALID = 2'b11;

    localparam int NUM_PORTS = 3;

    typedef enum logic [1:0] {
        PORT_L = 2'd0,
        PORT_R = 2'd1,
        PORT_S = 2'd2
    } port_t;

    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_STROBE = 2'd1,
        P_HOLD   = 2'd2
    } pstate_t;

endpackage

// File: rtl/transmitter_queue_if.sv
// Controller-side input and ring-side outputs of the transmit queue.
interface transmitter_queue_if #(
    parameter int width = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [width-1:0] in_sig;
    logic             in_wr;
    logic [1:0]       in_src;
    logic             in_ready;
    logic [width-1:0] out_sig_left;
    logic [width-1:0] out_sig_right;
    logic [width-1:0] out_sig_self;
    logic             send_l;
    logic             send_r;
    logic             send_s;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             drop;

    modport master (
        output in_sig, in_wr, in_src,
        input  in_ready, out_sig_left, out_sig_right, out_sig_self,
        input  send_l, send_r, send_s, full, empty, count, drop
    );

    modport slave (
        input  in_sig, in_wr, in_src,
        output in_ready, out_sig_left, out_sig_right, out_sig_self,
        output send_l, send_r, send_s, full, empty, count, drop
    );
endinterface

// File: rtl/msg_fifo.sv
// Synchronous FIFO with registered occupancy flags; push while full is
// accepted only when a pop happens in the same cycle.
module msg_fifo #(
    parameter int width = 34,
    parameter int depth = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [width-1:0]       wdata,
    output logic [width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count
);
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth) + 1;

    logic [width-1:0] mem_r [depth];
    logic [AW-1:0]    wptr_r, rptr_r;
    logic [CW-1:0]    count_r, count_nxt_s;
    logic             full_r, empty_r;
    logic             do_push_s, do_pop_s;

    assign do_pop_s  = pop && !empty_r;
    assign do_push_s = push && (!full_r || do_pop_s);

    // Occupancy after this edge
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (do_push_s) wptr_r <= wptr_r + AW'(1);
            if (do_pop_s)  rptr_r <= rptr_r + AW'(1);
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(depth));
            empty_r <= (count_nxt_s == {CW{1'b0}});
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wptr_r] <= wdata;
    end

    assign rdata = mem_r[rptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;
endmodule

// File: rtl/transmitter_queue.sv
// Outbound half of a ring node: route each message at push time, queue it,
// then strobe it out on the left, right or local port in strict FIFO order.
module transmitter_queue
    import ring_pkg::*;
#(
    parameter int width      = 32,
    parameter int addr_bits  = 3,
    parameter int RING_NODES = 8,
    parameter int NODE_ID    = 0,
    parameter int DEPTH      = 4,
    parameter int HOLD       = 2
) (
    input logic                clk,
    input logic                reset,
    transmitter_queue_if.slave bus
);
    localparam int EW = width + 2;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [addr_bits-1:0] dest_s;
    logic [31:0]          dist_s;
    logic                 invalid_s;
    port_t                tag_s;
    logic                 push_s, pop_s;
    logic [EW-1:0]        head_s;
    logic [1:0]           head_tag_s;
    logic                 full_s, empty_s;
    logic [CW-1:0]        count_s;
    logic                 drop_r;
    logic [NUM_PORTS-1:0] pop_req_s;
    logic [NUM_PORTS-1:0] send_vec_s;
    logic [width-1:0]     data_s [NUM_PORTS];

    // Destination decode; transit keeps direction, local traffic takes the shorter arc
    always_comb begin
        dest_s    = bus.in_sig[width-1 -: addr_bits];
        dist_s    = (32'(dest_s) + 32'(RING_NODES) - 32'(NODE_ID)) % 32'(RING_NODES);
        invalid_s = (32'(dest_s) >= 32'(RING_NODES)) || (bus.in_src == SRC_INVALID);
        tag_s     = PORT_S;
        if (32'(dest_s) == 32'(NODE_ID)) begin
            tag_s = PORT_S;
        end else begin
            case (bus.in_src)
                SRC_LEFT:  tag_s = PORT_R;
                SRC_RIGHT: tag_s = PORT_L;
                SRC_SELF: begin
                    if (dist_s <= 32'(RING_NODES / 2)) tag_s = PORT_R;
                    else                               tag_s = PORT_L;
                end
                default:   tag_s = PORT_S;
            endcase
        end
    end

    assign pop_s  = |pop_req_s;
    assign push_s = bus.in_wr && !invalid_s && (!full_s || pop_s);

    // Drop pulse for any write that was not stored
    always_ff @(posedge clk) begin
        if (reset) drop_r <= 1'b0;
        else       drop_r <= bus.in_wr && !push_s;
    end

    msg_fifo #(.width(EW), .depth(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({tag_s, bus.in_sig}),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign head_tag_s = head_s[EW-1 -: 2];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        pstate_t          state_r, state_nxt_s;
        logic [HW-1:0]    cnt_r;
        logic             send_r;
        logic [width-1:0] data_r;
        logic             free_s;

        // The last HOLD cycle doubles as idle so strobes repeat every 1+HOLD cycles
        assign free_s       = (state_r == P_IDLE) ||
                              ((state_r == P_HOLD) && (cnt_r == HW'(HOLD - 1)));
        assign pop_req_s[p] = free_s && !empty_s && (head_tag_s == 2'(p));

        // Port next-state
        always_comb begin
            state_nxt_s = state_r;
            case (state_r)
                P_IDLE: begin
                    if (pop_req_s[p]) state_nxt_s = P_STROBE;
                    else              state_nxt_s = P_IDLE;
                end
                P_STROBE: state_nxt_s = P_HOLD;
                P_HOLD: begin
                    if (pop_req_s[p])                    state_nxt_s = P_STROBE;
                    else if (cnt_r == HW'(HOLD - 1))     state_nxt_s = P_IDLE;
                    else                                 state_nxt_s = P_HOLD;
                end
                default: state_nxt_s = P_IDLE;
            endcase
        end

        // Port state, hold counter, strobe and data registers
        always_ff @(posedge clk) begin
            if (reset) begin
                state_r <= P_IDLE;
                cnt_r   <= {HW{1'b0}};
                send_r  <= 1'b0;
                data_r  <= {width{1'b0}};
            end else begin
                state_r <= state_nxt_s;
                if ((state_r == P_HOLD) && (state_nxt_s == P_HOLD)) cnt_r <= cnt_r + HW'(1);
                else                                                cnt_r <= {HW{1'b0}};
                send_r <= pop_req_s[p];
                if (pop_req_s[p]) data_r <= head_s[width-1:0];
            end
        end

        assign send_vec_s[p] = send_r;
        assign data_s[p]     = data_r;
    end

    assign bus.send_l        = send_vec_s[PORT_L];
    assign bus.send_r        = send_vec_s[PORT_R];
    assign bus.send_s        = send_vec_s[PORT_S];
    assign bus.out_sig_left  = data_s[PORT_L];
    assign bus.out_sig_right = data_s[PORT_R];
    assign bus.out_sig_self  = data_s[PORT_S];
    assign bus.full          = full_s;
    assign bus.empty         = empty_s;
    assign bus.count         = count_s;
    assign bus.in_ready      = !full_s;
    assign bus.drop          = drop_r;
endmodule

// File: tb/tb_transmitter_queue.sv
// Directed bench for transmitter_queue at NODE_ID=2, RING_NODES=8, HOLD=2, DEPTH=4;
// a second instance with 4-bit addresses covers out-of-ring destinations.
module tb_transmitter_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    transmitter_queue_if #(.width(32), .DEPTH(4)) bus ();
    transmitter_queue_if #(.width(32), .DEPTH(4)) bus4 ();

    transmitter_queue #(.width(32), .addr_bits(3), .RING_NODES(8), .NODE_ID(2),
                        .DEPTH(4), .HOLD(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    transmitter_queue #(.width(32), .addr_bits(4), .RING_NODES(8), .NODE_ID(2),
                        .DEPTH(4), .HOLD(2)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    always @(posedge clk) cyc <= cyc + 1;

    int          l_t[$], r_t[$], s_t[$], d_t[$];
    logic [31:0] l_d[$], r_d[$], s_d[$];
    int          drop4_n = 0;
    int          send4_n = 0;

    // Event log: cycle index of every strobe and drop, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.send_l) begin l_t.push_back(cyc); l_d.push_back(bus.out_sig_left); end
        if (bus.send_r) begin r_t.push_back(cyc); r_d.push_back(bus.out_sig_right); end
        if (bus.send_s) begin s_t.push_back(cyc); s_d.push_back(bus.out_sig_self); end
        if (bus.drop) d_t.push_back(cyc);
        if (bus4.drop) drop4_n = drop4_n + 1;
        if (bus4.send_l || bus4.send_r || bus4.send_s) send4_n = send4_n + 1;
    end

    task automatic clr();
        l_t.delete(); r_t.delete(); s_t.delete(); d_t.delete();
        l_d.delete(); r_d.delete(); s_d.delete();
    endtask

    task automatic wr(input logic [31:0] m, input logic [1:0] src);
        bus.in_sig = m; bus.in_src = src; bus.in_wr = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_wr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if ({bus.empty, bus.full, bus.in_ready} !== 3'b101) begin errors++; $display("FAIL reset_flags got=%b exp=101", {bus.empty, bus.full, bus.in_ready}); end
        checks++; if ({bus.send_l, bus.send_r, bus.send_s, bus.drop} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {bus.send_l, bus.send_r, bus.send_s, bus.drop}); end
        checks++; if ((bus.out_sig_left | bus.out_sig_right | bus.out_sig_self) !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.out_sig_left | bus.out_sig_right | bus.out_sig_self); end
    endtask

    task automatic test_local();
        int t0;
        clr(); t0 = cyc + 1;
        wr(32'h4000_00AA, 2'b01);
        idle(2);
        checks++; if ({bus.send_s, bus.out_sig_self} !== {1'b0, 32'h4000_00AA}) begin errors++; $display("FAIL local_hold got=%b/%h exp=0/400000aa", bus.send_s, bus.out_sig_self); end
        idle(4);
        checks++; if (s_t.size() !== 1) begin errors++; $display("FAIL local_nstrobe got=%0d exp=1", s_t.size()); end
        else begin
            checks++; if (s_t[0] !== t0 + 1) begin errors++; $display("FAIL local_time got=%0d exp=%0d", s_t[0], t0 + 1); end
            checks++; if (s_d[0] !== 32'h4000_00AA) begin errors++; $display("FAIL local_data got=%h exp=400000aa", s_d[0]); end
        end
        checks++; if (l_t.size() + r_t.size() !== 0) begin errors++; $display("FAIL local_other got=%0d exp=0", l_t.size() + r_t.size()); end
        checks++; if ({bus.empty, bus.out_sig_self} !== {1'b1, 32'h4000_00AA}) begin errors++; $display("FAIL local_after got=%b/%h exp=1/400000aa", bus.empty, bus.out_sig_self); end
    endtask

    task automatic test_routing();
        int t0;
        clr(); t0 = cyc + 1;
        wr(32'h6000_0003, 2'b01);
        wr(32'hE000_0007, 2'b01);
        wr(32'hC000_0006, 2'b01);
        idle(10);
        checks++; if (r_t.size() !== 2) begin errors++; $display("FAIL route_nr got=%0d exp=2", r_t.size()); end
        else begin
            checks++; if ({r_t[0], r_t[1]} !== {t0 + 1, t0 + 4}) begin errors++; $display("FAIL route_rtime got=%0d,%0d exp=%0d,%0d", r_t[0], r_t[1], t0 + 1, t0 + 4); end
            checks++; if ({r_d[0], r_d[1]} !== {32'h6000_0003, 32'hC000_0006}) begin errors++; $display("FAIL route_rdata got=%h,%h exp=60000003,c0000006", r_d[0], r_d[1]); end
        end
        checks++; if (l_t.size() !== 1) begin errors++; $display("FAIL route_nl got=%0d exp=1", l_t.size()); end
        else begin
            checks++; if ({l_t[0], l_d[0]} !== {t0 + 2, 32'hE000_0007}) begin errors++; $display("FAIL route_l got=%0d/%h exp=%0d/e0000007", l_t[0], l_d[0], t0 + 2); end
        end
    endtask

    task automatic test_transit();
        int t0, t1, t2;
        clr(); t0 = cyc + 1;
        wr(32'hA000_0005, 2'b00); idle(5);
        t1 = cyc + 1;
        wr(32'h0000_0010, 2'b10); idle(5);
        t2 = cyc + 1;
        wr(32'h4000_0001, 2'b11); idle(5);
        checks++; if (r_t.size() !== 1) begin errors++; $display("FAIL transit_nr got=%0d exp=1", r_t.size()); end
        else begin
            checks++; if ({r_t[0], r_d[0]} !== {t0 + 1, 32'hA000_0005}) begin errors++; $display("FAIL transit_r got=%0d/%h exp=%0d/a0000005", r_t[0], r_d[0], t0 + 1); end
        end
        checks++; if (l_t.size() !== 1) begin errors++; $display("FAIL transit_nl got=%0d exp=1", l_t.size()); end
        else begin
            checks++; if ({l_t[0], l_d[0]} !== {t1 + 1, 32'h0000_0010}) begin errors++; $display("FAIL transit_l got=%0d/%h exp=%0d/00000010", l_t[0], l_d[0], t1 + 1); end
        end
        checks++; if (s_t.size() !== 0) begin errors++; $display("FAIL invalid_src_sent got=%0d exp=0", s_t.size()); end
        checks++; if (d_t.size() !== 1) begin errors++; $display("FAIL invalid_src_ndrop got=%0d exp=1", d_t.size()); end
        else begin
            checks++; if (d_t[0] !== t2) begin errors++; $display("FAIL invalid_src_droptime got=%0d exp=%0d", d_t[0], t2); end
        end
        drop4_n = 0; send4_n = 0;
        bus4.in_sig = 32'h9000_0000; bus4.in_src = 2'b01; bus4.in_wr = 1'b1;
        @(negedge clk);
        bus4.in_wr = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if ({drop4_n, send4_n} !== {32'd1, 32'd0}) begin errors++; $display("FAIL dest9 drops/sends got=%0d/%0d exp=1/0", drop4_n, send4_n); end
        checks++; if (bus4.count !== 3'd0) begin errors++; $display("FAIL dest9_count got=%0d exp=0", bus4.count); end
        bus4.in_sig = 32'h2000_0000; bus4.in_wr = 1'b1;
        @(negedge clk);
        bus4.in_wr = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if ({drop4_n, send4_n, bus4.out_sig_self} !== {32'd1, 32'd1, 32'h2000_0000}) begin errors++; $display("FAIL dest2_wide got=%0d/%0d/%h exp=1/1/20000000", drop4_n, send4_n, bus4.out_sig_self); end
    endtask

    task automatic test_overflow();
        int t0;
        clr(); t0 = cyc + 1;
        for (int k = 0; k < 7; k++) wr(32'h6000_0000 + 32'(k), 2'b01);
        checks++; if ({bus.full, bus.in_ready, bus.count} !== {1'b1, 1'b0, 3'd4}) begin errors++; $display("FAIL ovf_full got=%b/%b/%0d exp=1/0/4", bus.full, bus.in_ready, bus.count); end
        idle(20);
        checks++; if (d_t.size() !== 1) begin errors++; $display("FAIL ovf_ndrop got=%0d exp=1", d_t.size()); end
        else begin
            checks++; if (d_t[0] !== t0 + 6) begin errors++; $display("FAIL ovf_droptime got=%0d exp=%0d", d_t[0], t0 + 6); end
        end
        checks++; if (r_t.size() !== 6) begin errors++; $display("FAIL ovf_nr got=%0d exp=6", r_t.size()); end
        else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if ({r_t[k], r_d[k]} !== {t0 + 1 + 3 * k, 32'h6000_0000 + 32'(k)}) begin
                    errors++; $display("FAIL ovf_msg%0d got=%0d/%h exp=%0d/%h", k, r_t[k], r_d[k], t0 + 1 + 3 * k, 32'h6000_0000 + 32'(k));
                end
            end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_reset_mid();
        int t1;
        clr();
        for (int k = 0; k < 5; k++) wr(32'h6000_0010 + 32'(k), 2'b01);
        checks++; if ({bus.send_r, bus.out_sig_right, bus.count} !== {1'b1, 32'h6000_0011, 3'd3}) begin errors++; $display("FAIL mid_pre got=%b/%h/%0d exp=1/60000011/3", bus.send_r, bus.out_sig_right, bus.count); end
        bus.in_wr = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if ({bus.send_r, bus.out_sig_right, bus.count, bus.empty, bus.full, bus.drop} !== {1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mid_reset got=%b/%h/%0d/%b/%b/%b exp=0/0/0/1/0/0", bus.send_r, bus.out_sig_right, bus.count, bus.empty, bus.full, bus.drop);
        end
        idle(10);
        checks++; if (r_t.size() !== 2) begin errors++; $display("FAIL mid_nostrobe got=%0d exp=2", r_t.size()); end
        clr(); t1 = cyc + 1;
        wr(32'h4000_0055, 2'b01);
        idle(4);
        checks++; if (s_t.size() !== 1) begin errors++; $display("FAIL mid_after_n got=%0d exp=1", s_t.size()); end
        else begin
            checks++; if ({s_t[0], s_d[0]} !== {t1 + 1, 32'h4000_0055}) begin errors++; $display("FAIL mid_after got=%0d/%h exp=%0d/40000055", s_t[0], s_d[0], t1 + 1); end
        end
    endtask

    task automatic test_hol();
        int t0;
        clr(); t0 = cyc + 1;
        wr(32'h6000_0021, 2'b01);
        wr(32'h6000_0022, 2'b01);
        wr(32'h4000_0023, 2'b01);
        idle(10);
        checks++; if (r_t.size() !== 2) begin errors++; $display("FAIL hol_nr got=%0d exp=2", r_t.size()); end
        else begin
            checks++; if ({r_t[0], r_t[1]} !== {t0 + 1, t0 + 4}) begin errors++; $display("FAIL hol_rtime got=%0d,%0d exp=%0d,%0d", r_t[0], r_t[1], t0 + 1, t0 + 4); end
        end
        checks++; if (s_t.size() !== 1) begin errors++; $display("FAIL hol_ns got=%0d exp=1", s_t.size()); end
        else begin
            checks++; if ({s_t[0], s_d[0]} !== {t0 + 5, 32'h4000_0023}) begin errors++; $display("FAIL hol_s got=%0d/%h exp=%0d/40000023", s_t[0], s_d[0], t0 + 5); end
        end
    endtask

    initial begin
        bus.in_sig = 32'h0; bus.in_wr = 1'b0; bus.in_src = 2'b00;
        bus4.in_sig = 32'h0; bus4.in_wr = 1'b0; bus4.in_src = 2'b00;
        test_reset();
        test_local();
        test_routing();
        test_transit();
        test_overflow();
        test_reset_mid();
        test_hol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
